// File: rtl/ray_pkg.sv
// ray_pkg: shared word layout, sync tag field, FSM states and record field offsets for ray assembly.
package ray_pkg;
  localparam int WORD_W = 36;
  localparam int TAG_HI = 35;
  localparam int TAG_LO = 32;
  localparam logic [3:0] DEF_SYNC_TAG = 4'hA;
  localparam logic [1:0] ST_HUNT = 2'd0;
  localparam logic [1:0] ST_COLLECT = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;
  typedef enum logic [1:0] {HUNT = ST_HUNT, COLLECT = ST_COLLECT, HOLD = ST_HOLD} state_t;
  localparam int ORIG_X = 0;
  localparam int ORIG_Y = 1;
  localparam int ORIG_Z = 2;
  localparam int DIR_X = 3;
  localparam int DIR_Y = 4;
  localparam int DIR_Z = 5;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: event counter that either saturates at all-ones or wraps, selected by SAT.
module sat_counter #(
  parameter int W = 16,
  parameter bit SAT = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= '0;
    else if (inc && !(SAT && &q)) q <= q + 1'b1;
endmodule

// File: rtl/ray_word_assembler.sv
// ray_word_assembler: pops tagged 36-bit FIFO words into WORDS-word ray records and hands them off over valid/ready.
module ray_word_assembler
  import ray_pkg::*;
#(
  parameter int WORDS = 6,
  parameter logic [3:0] SYNC_TAG = DEF_SYNC_TAG,
  parameter int CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [WORD_W-1:0]       fifo_rd_data,
  input  logic                    fifo_empty,
  output logic                    fifo_rd_en,
  output logic [WORDS*WORD_W-1:0] ray_data,
  output logic                    ray_valid,
  input  logic                    ray_ready,
  output logic [CNT_W-1:0]        ray_count,
  output logic [CNT_W-1:0]        sync_err_cnt,
  output logic                    busy
);
  localparam int IDX_W = $clog2(WORDS);
  state_t state;
  logic [IDX_W-1:0] idx;
  logic [WORDS-1:0][WORD_W-1:0] slot;
  logic tag_ok, hit, last;
  assign tag_ok = fifo_rd_data[TAG_HI:TAG_LO] == SYNC_TAG;
  // the FIFO does not guard underflow, so every pop is gated here
  assign fifo_rd_en = rst_n && !fifo_empty && (state != HOLD || ray_ready);
  assign hit = fifo_rd_en && tag_ok;
  assign last = idx == IDX_W'(WORDS - 1);
  assign busy = state != HUNT;
  assign ray_data = slot;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= HUNT;
      idx <= '0;
      ray_valid <= 1'b0;
    end else if (state == COLLECT) begin
      if (fifo_rd_en && last) begin
        state <= HOLD;
        ray_valid <= 1'b1;
      end else if (fifo_rd_en) idx <= idx + 1'b1;
    end else if (state == HUNT || ray_ready) begin
      // HUNT, or a HOLD handshake that may already pop the next header
      state <= hit ? COLLECT : HUNT;
      idx <= hit ? IDX_W'(1) : '0;
      ray_valid <= 1'b0;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) slot <= '0;
    else for (int k = 0; k < WORDS; k++)
      if (fifo_rd_en && (state == COLLECT ? idx == IDX_W'(k) : k == 0 && tag_ok))
        slot[k] <= fifo_rd_data;
  sat_counter #(.W(CNT_W), .SAT(1'b0)) u_ray_cnt (
    .clk(clk), .rst_n(rst_n), .inc(state == HOLD && ray_ready), .q(ray_count)
  );
  sat_counter #(.W(CNT_W), .SAT(1'b1)) u_err_cnt (
    .clk(clk), .rst_n(rst_n), .inc(fifo_rd_en && state != COLLECT && !tag_ok), .q(sync_err_cnt)
  );
endmodule
